perceptron_loader: RTL

Host-side load/run/readback controller for the perceptron trainer. It receives a byte command stream, stores the training set (samples, labels) and initial weights in local registers, and sequences training epochs by streaming samples to the trainer over a valid/ready port. After each sample it captures the updated weights and returns results over a byte response channel. It sits between the chip's dedicated I/O pins and the perceptron datapath, replacing hardcoded initial data.

---
 rtl/perceptron_loader.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/perceptron_loader.sv
// Host-side command loader for the perceptron trainer: stores samples and weights,
// sequences training epochs over a valid/ready port, and answers over a byte channel.
module perceptron_loader #(
    parameter int N_SAMPLES = 3,
    parameter int DW        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    input  logic [7:0]      cmd_data,
    output logic            cmd_ready,
    output logic            rsp_valid,
    output logic [7:0]      rsp_data,
    input  logic            rsp_ready,
    output logic            smp_valid,
    input  logic            smp_ready,
    output logic [3:0]      smp_x0,
    output logic [3:0]      smp_x1,
    output logic            smp_y,
    output logic [3:0]      smp_idx,
    output logic [DW-1:0]   w0,
    output logic [DW-1:0]   w1,
    input  logic            w_upd_valid,
    input  logic [2*DW-1:0] w_upd,
    output logic            busy
);

    typedef enum logic [2:0] {IDLE, PAY1, PAY2, RUN_SEND, RUN_WAIT, RSP1, RSP2} state_t;

    localparam logic [4:0] NS   = 5'(N_SAMPLES);
    localparam logic [3:0] LAST = 4'(N_SAMPLES - 1);
    localparam logic [7:0] RSP_OK  = 8'h01;
    localparam logic [7:0] RSP_ERR = 8'hEE;
    localparam logic [7:0] RSP_RUN = 8'hA5;

    state_t     state, state_nx;
    logic [3:0] op, arg;
    logic [7:0] stage, rsp_next;
    logic       rsp_two;
    logic [3:0] smp_cnt;
    logic [4:0] epoch_cnt, epoch_tgt;

    // Storage sized for the largest index the 4-bit argument can name; only
    // entries below N_SAMPLES are ever written.
    logic [3:0] x0_mem [16];
    logic [3:0] x1_mem [16];
    logic       y_mem  [16];

    logic cmd_fire, rsp_fire, smp_fire, arg_ok, cmd_arg_ok, last_smp, last_epoch;

    assign cmd_fire   = cmd_valid && cmd_ready;
    assign rsp_fire   = rsp_valid && rsp_ready;
    assign smp_fire   = smp_valid && smp_ready;
    assign arg_ok     = {1'b0, arg} < NS;
    assign cmd_arg_ok = {1'b0, cmd_data[3:0]} < NS;
    assign last_smp   = smp_cnt == LAST;
    assign last_epoch = (epoch_cnt + 5'd1) == epoch_tgt;

    assign smp_idx = smp_cnt;
    assign smp_x0  = x0_mem[smp_cnt];
    assign smp_x1  = x1_mem[smp_cnt];
    assign smp_y   = y_mem[smp_cnt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        smp_valid = 1'b0;
        rsp_valid = 1'b0;
        busy      = state != IDLE;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_data[7:4])
                        4'h1, 4'h2: state_nx = PAY1;
                        4'h3:       state_nx = RUN_SEND;
                        default:    state_nx = RSP1;
                    endcase
                end
            end
            PAY1: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nx = (op == 4'h1) ? PAY2 : RSP1;
            end
            PAY2: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nx = RSP1;
            end
            RUN_SEND: begin
                smp_valid = 1'b1;
                if (smp_ready) state_nx = RUN_WAIT;
            end
            RUN_WAIT: begin
                if (w_upd_valid) state_nx = (last_smp && last_epoch) ? RSP1 : RUN_SEND;
            end
            RSP1: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = rsp_two ? RSP2 : IDLE;
            end
            RSP2: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: the response byte is registered so it stays put under backpressure;
    // a two-byte reply keeps its second byte in rsp_next until the first is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op        <= '0;
            arg       <= '0;
            stage     <= '0;
            rsp_data  <= '0;
            rsp_next  <= '0;
            rsp_two   <= 1'b0;
            w0        <= '0;
            w1        <= '0;
            smp_cnt   <= '0;
            epoch_cnt <= '0;
            epoch_tgt <= '0;
            for (int i = 0; i < 16; i++) begin
                x0_mem[i] <= '0;
                x1_mem[i] <= '0;
                y_mem[i]  <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: if (cmd_fire) begin
                    op      <= cmd_data[7:4];
                    arg     <= cmd_data[3:0];
                    rsp_two <= 1'b0;
                    case (cmd_data[7:4])
                        4'h1, 4'h2: ;
                        4'h3: begin
                            smp_cnt   <= '0;
                            epoch_cnt <= '0;
                            epoch_tgt <= (cmd_data[3:0] == 4'h0) ? 5'd16 : {1'b0, cmd_data[3:0]};
                        end
                        4'h4: begin
                            rsp_data <= 8'(w0);
                            rsp_next <= 8'(w1);
                            rsp_two  <= 1'b1;
                        end
                        4'h5: begin
                            if (cmd_arg_ok) begin
                                rsp_data <= {x1_mem[cmd_data[3:0]], x0_mem[cmd_data[3:0]]};
                                rsp_next <= {7'b0, y_mem[cmd_data[3:0]]};
                                rsp_two  <= 1'b1;
                            end else begin
                                rsp_data <= RSP_ERR;
                            end
                        end
                        default: rsp_data <= RSP_ERR;
                    endcase
                end
                PAY1: if (cmd_fire) begin
                    if (op == 4'h1) begin
                        stage <= cmd_data;
                    end else if (arg == 4'h0) begin
                        w0       <= DW'(cmd_data);
                        rsp_data <= RSP_OK;
                    end else if (arg == 4'h1) begin
                        w1       <= DW'(cmd_data);
                        rsp_data <= RSP_OK;
                    end else begin
                        rsp_data <= RSP_ERR;
                    end
                end
                PAY2: if (cmd_fire) begin
                    if (arg_ok) begin
                        x0_mem[arg] <= stage[3:0];
                        x1_mem[arg] <= stage[7:4];
                        y_mem[arg]  <= cmd_data[0];
                        rsp_data    <= RSP_OK;
                    end else begin
                        rsp_data <= RSP_ERR;
                    end
                end
                RUN_WAIT: if (w_upd_valid) begin
                    w0 <= w_upd[DW-1:0];
                    w1 <= w_upd[2*DW-1:DW];
                    if (last_smp) begin
                        smp_cnt   <= '0;
                        epoch_cnt <= epoch_cnt + 5'd1;
                        if (last_epoch) rsp_data <= RSP_RUN;
                    end else begin
                        smp_cnt <= smp_cnt + 4'd1;
                    end
                end
                RSP1: if (rsp_fire && rsp_two) rsp_data <= rsp_next;
                default: ;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = smp_fire;

endmodule
